// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and request legality decode.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    STORE,
    RESP
  } lsu_state_e;

  // True when the request must be answered with an error and no memory access.
  function automatic logic req_illegal(input logic       we,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
    logic legal_f3;
    logic misaligned;
    if (we) legal_f3 = funct3 inside {F3_B, F3_H, F3_W};
    else    legal_f3 = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    case (funct3[1:0])
      2'b01:   misaligned = addr_lo[0];
      2'b10:   misaligned = (addr_lo != 2'b00);
      default: misaligned = 1'b0;
    endcase
    return !legal_f3 || misaligned;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Little-endian lane handling: load extract/extend and sub-word store merge.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  f3);
    logic [31:0] shifted;
    shifted = word >> {lane, 3'b000};
    case (f3)
      F3_B:    return {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    return {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   return {24'h0, shifted[7:0]};
      F3_HU:   return {16'h0, shifted[15:0]};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                              input logic [31:0] new_data,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  f3);
    logic [31:0] merged;
    merged = old_word;
    case (f3)
      F3_B:    merged[{lane, 3'b000} +: 8]     = new_data[7:0];
      F3_H:    merged[{lane[1], 4'b0000} +: 16] = new_data[15:0];
      default: merged = new_data;
    endcase
    return merged;
  endfunction

  assign load_data  = load_extend(rdata, addr_lo, funct3);
  assign store_data = store_merge(rdata, wdata, addr_lo, funct3);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core request at a time and drives a word-wide
// data memory with combinational read and synchronous write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32  // only 32 is supported
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] merge_q;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] store_data;
  logic              accept;
  logic              accept_err;

  assign accept     = (state_q == IDLE) && req_valid;
  assign accept_err = req_illegal(req_we, req_funct3, req_addr[1:0]);

  lsu_align u_align (
    .rdata      (mem_rdata),
    .wdata      (wdata_q),
    .addr_lo    (addr_q[1:0]),
    .funct3     (funct3_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would infer a latch.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    resp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (accept_err)                state_d = RESP;
          else if (!req_we)              state_d = LOAD;
          else if (req_funct3 == F3_W)   state_d = STORE;
          else                           state_d = RMW_RD;
        end
      end
      LOAD: begin
        mem_read = 1'b1;
        state_d  = RESP;
      end
      RMW_RD: begin
        mem_read = 1'b1;
        state_d  = STORE;
      end
      STORE: begin
        mem_write = 1'b1;
        state_d   = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory port is decoded from state and registered fields only.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_read || mem_write) mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    if (mem_write)             mem_wdata = merge_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      merge_q    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            merge_q  <= req_wdata;
            if (accept_err) begin
              resp_rdata <= '0;
              resp_err   <= 1'b1;
            end
          end
        end
        LOAD: begin
          resp_rdata <= load_data;
          resp_err   <= 1'b0;
        end
        RMW_RD: merge_q <= store_data;
        STORE: begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory model attached.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:255] = '{default: 32'h0};
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;

  // Pulse monitor, sampled mid-cycle.
  int          cyc = 0;
  int          rd_total = 0, wr_total = 0, both_total = 0;
  int          rd_cyc = 0, wr_cyc = 0;
  logic [31:0] rd_addr_l = '0, wr_addr_l = '0, wr_data_l = '0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (mem_read)  begin rd_total++; rd_addr_l = mem_addr; rd_cyc = cyc; end
    if (mem_write) begin wr_total++; wr_addr_l = mem_addr; wr_data_l = mem_wdata; wr_cyc = cyc; end
    if (mem_read && mem_write) both_total++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      if (resp_valid) begin lat = i; break; end
      @(negedge clk);
    end
  endtask

  task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int exp_lat, input logic exp_err, input logic [31:0] exp_rdata,
                     input int exp_rd, input int exp_wr);
    int rd0, wr0, lat;
    @(negedge clk);
    check({tag, "_ready"}, req_ready, 1);
    rd0 = rd_total;
    wr0 = wr_total;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    wait_resp(lat);
    check({tag, "_lat"},   lat, exp_lat);
    check({tag, "_err"},   resp_err, exp_err);
    check({tag, "_rdata"}, resp_rdata, exp_rdata);
    check({tag, "_rd"},    rd_total - rd0, exp_rd);
    check({tag, "_wr"},    wr_total - wr0, exp_wr);
  endtask

  initial begin
    int lat, seen;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;

    #12;
    check("rst_ready",      req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_err",   resp_err, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_mem_read",   mem_read, 0);
    check("rst_mem_write",  mem_write, 0);
    check("rst_mem_addr",   mem_addr, 0);
    check("rst_mem_wdata",  mem_wdata, 0);
    @(negedge clk);
    reset = 1'b0;

    txn("sw40", 1'b1, F3_W, 32'h40, 32'h8000_7F80, 2, 1'b0, 32'h0, 0, 1);
    check("sw40_addr",  wr_addr_l, 32'h40);
    check("sw40_wdata", wr_data_l, 32'h8000_7F80);

    txn("lb40",  1'b0, F3_B,  32'h40, 32'h0, 2, 1'b0, 32'hFFFF_FF80, 1, 0);
    check("lb40_addr", rd_addr_l, 32'h40);
    txn("lbu40", 1'b0, F3_BU, 32'h40, 32'h0, 2, 1'b0, 32'h0000_0080, 1, 0);
    txn("lb41",  1'b0, F3_B,  32'h41, 32'h0, 2, 1'b0, 32'h0000_007F, 1, 0);
    check("lb41_addr", rd_addr_l, 32'h40);
    txn("lh42",  1'b0, F3_H,  32'h42, 32'h0, 2, 1'b0, 32'hFFFF_8000, 1, 0);
    txn("lhu42", 1'b0, F3_HU, 32'h42, 32'h0, 2, 1'b0, 32'h0000_8000, 1, 0);
    check("lhu42_addr", rd_addr_l, 32'h40);
    txn("lw40",  1'b0, F3_W,  32'h40, 32'h0, 2, 1'b0, 32'h8000_7F80, 1, 0);

    txn("sb43", 1'b1, F3_B, 32'h43, 32'h1234_56AB, 3, 1'b0, 32'h0, 1, 1);
    check("sb43_wdata",   wr_data_l, 32'hAB00_7F80);
    check("sb43_rd_then_wr", rd_cyc < wr_cyc, 1);
    txn("sh40", 1'b1, F3_H, 32'h40, 32'h0000_BEEF, 3, 1'b0, 32'h0, 1, 1);
    check("sh40_wdata", wr_data_l, 32'hAB00_BEEF);
    txn("lw40b", 1'b0, F3_W, 32'h40, 32'h0, 2, 1'b0, 32'hAB00_BEEF, 1, 0);

    txn("err_lw42",  1'b0, F3_W,   32'h42, 32'h0,        1, 1'b1, 32'h0, 0, 0);
    txn("err_sh41",  1'b1, F3_H,   32'h41, 32'hFFFF_FFFF, 1, 1'b1, 32'h0, 0, 0);
    txn("err_f3011", 1'b0, 3'b011, 32'h40, 32'h0,        1, 1'b1, 32'h0, 0, 0);

    // Back-pressure: req_valid stays high across two requests.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h40; req_wdata = '0;
    @(posedge clk);
    #1 check("bp_ready_after_accept", req_ready, 0);
    @(negedge clk);
    req_we = 1'b1; req_funct3 = F3_B; req_addr = 32'h45; req_wdata = 32'h7777_77CD;
    check("bp_ready_c1", req_ready, 0);
    @(negedge clk);
    check("bp_resp_valid_a", resp_valid, 1);
    check("bp_ready_resp",   req_ready, 0);
    check("bp_rdata_a",      resp_rdata, 32'hAB00_BEEF);
    @(negedge clk);
    check("bp_ready_after_resp", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("bp_ready_b_busy", req_ready, 0);
    wait_resp(lat);
    check("bp_lat_b",   lat, 3);
    check("bp_addr_b",  wr_addr_l, 32'h44);
    check("bp_wdata_b", wr_data_l, 32'h0000_CD00);

    // Reset while an SB sits in STORE: the write must never commit.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_B; req_addr = 32'h48; req_wdata = 32'h0000_00FF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rs_rmw_read", mem_read, 1);
    @(negedge clk);
    check("rs_store_write", mem_write, 1);
    check("rs_store_wdata", mem_wdata, 32'h0000_00FF);
    #2 reset = 1'b1;
    #1;
    check("rs_write_drop", mem_write, 0);
    check("rs_addr_drop",  mem_addr, 0);
    check("rs_wdata_drop", mem_wdata, 0);
    check("rs_ready",      req_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid) seen++;
      @(negedge clk);
    end
    check("rs_no_resp",    seen, 0);
    check("rs_ready_post", req_ready, 1);
    txn("rs_lw48", 1'b0, F3_W, 32'h48, 32'h0, 2, 1'b0, 32'h0, 1, 0);

    check("never_both", both_total, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the core's data-memory port; sits between the execute stage and the word-addressed data memory.
- The data memory has a combinational read, a synchronous word-only write, ports MemRead/MemWrite/addr/write_data/read_data, and uses addr[31:2] as the word index.
- This block accepts byte, halfword and word load/store requests from the core over a valid/ready handshake and drives that memory port.
- Loads: extracts the addressed lane and sign- or zero-extends it. Sub-word stores: performs read-modify-write. Misaligned or illegal requests return an error with no memory access.

Parameters:
- ADDR_W, 32, byte-address width of req_addr and mem_addr.
- DATA_W, 32, data width. Fixed at 32; any other value is unsupported.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the relevant lane is taken from the low bits.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal funct3; qualified by resp_valid.
- mem_read  out  1  drives the memory's MemRead.
- mem_write  out  1  drives the memory's MemWrite.
- mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- mem_wdata  out  32  drives write_data.
- mem_rdata  in  32  from read_data; combinational in the same cycle as mem_read.

Behaviour:
- Reset (async, immediate):
  - State is IDLE.
  - resp_valid, resp_err, mem_read and mem_write are 0.
  - resp_rdata, mem_addr and mem_wdata are 0.
  - req_ready is 1.
- Registered request: on an accepted request, req_we, funct3, addr and wdata are registered. mem_* outputs are decoded from the state and registered fields only, never from req_* inputs.
- Byte ordering: little-endian. Byte k occupies bits [8k+7:8k]; halfword h occupies bits [16h+15:16h].
- States and transitions:
  - IDLE: req_ready=1. On req_valid:
    - Illegal funct3 (load 011/110/111; store other than 000/001/010) -> RESP with err.
    - Misaligned (halfword with addr[0]=1; word with addr[1:0]!=0) -> RESP with err.
    - Load -> LOAD.
    - SW -> STORE with merge register = wdata.
    - SB/SH -> RMW_RD.
  - LOAD: mem_read=1. Latch the extracted and extended mem_rdata into resp_rdata. -> RESP.
  - RMW_RD: mem_read=1. Latch mem_rdata with the new lane substituted into the merge register. -> STORE.
  - STORE: mem_write=1, mem_wdata=merge register. The write commits at this cycle's clock edge. -> RESP.
  - RESP: resp_valid=1 for exactly one cycle. -> IDLE. resp_rdata holds its value until the next response.
- Latency, counted from the accept edge to the cycle in which resp_valid is high:
  - Error: 1 cycle.
  - LW and SW: 2 cycles.
  - SB and SH: 3 cycles.
- Outstanding requests and ready:
  - At most one request is outstanding.
  - req_ready is 0 in every state except IDLE.
  - A request cannot be accepted in the RESP cycle; the next accept is earliest in the cycle after resp_valid.
- Pulse shape: mem_read and mem_write are never high together, and each is high for exactly one cycle per access.
- Reset asserted mid-operation:
  - All outputs drop immediately and the state returns to IDLE.
  - The in-flight request is abandoned; no resp_valid is issued for it.
  - A write is committed only if its STORE clock edge occurred before reset asserted.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants: F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - State enum: IDLE, LOAD, RMW_RD, STORE, RESP.
- Sub-module lsu_align (combinational), two functions:
  - Load extract and extend: inputs word, addr[1:0], funct3; output 32-bit value.
  - Store merge: inputs old word, wdata, addr[1:0], funct3; output merged word.
- The top level holds the FSM, request registers and handshake.

Test Plan:
- SW addr 0x40, wdata 0x80007F80:
  - Exactly one mem_write pulse with mem_addr=0x40, mem_wdata=0x80007F80, and no mem_read.
  - resp_valid 2 cycles after accept, resp_err=0.
- Loads after the previous store:
  - LB 0x40 -> 0xFFFFFF80.
  - LBU 0x40 -> 0x00000080.
  - LB 0x41 -> 0x0000007F.
  - LH 0x42 -> 0xFFFF8000.
  - LHU 0x42 -> 0x00008000.
  - LW 0x40 -> 0x80007F80.
  - Each load produces exactly one mem_read pulse at 0x40.
- SB addr 0x43, wdata 0x123456AB:
  - A mem_read pulse, then a mem_write pulse with mem_wdata=0xAB007F80; resp_valid 3 cycles after accept.
  - Follow with SH 0x40, wdata 0x0000BEEF -> mem_wdata 0xAB00BEEF.
  - Then LW 0x40 -> 0xAB00BEEF.
- Errors:
  - LW 0x42, SH 0x41, and load funct3=011 each -> resp_err=1 and resp_rdata=0, 1 cycle after accept.
  - No mem_read or mem_write pulse for any of them.
- Back-pressure:
  - Hold req_valid high continuously with two requests.
  - req_ready=0 from accept until the cycle after resp_valid; the second request is accepted only then.
  - The second request's fields are captured correctly.
- Reset mid-store:
  - Assert reset while in the STORE state of an SB -> mem_write drops to 0 in the same cycle, no resp_valid.
  - After release, req_ready=1 and state is IDLE.
